// File: rtl/hash_probe.sv
// hash_probe: two-beat bucket lookup over three hash tables.
// Beat-0 hits win over beat-1; within a beat table 1 > 2 > 3.
module hash_probe #(
    parameter int KEY_W   = 40,
    parameter int VAL_W   = 16,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   key_valid,
    input  logic [KEY_W-1:0]       key,
    output logic                   key_ready,
    input  logic                   hash_value_valid,
    input  logic [8:0]             hash_1,
    input  logic [8:0]             hash_2,
    input  logic [8:0]             hash_3,
    output logic                   rd_en_1,
    output logic                   rd_en_2,
    output logic                   rd_en_3,
    output logic [8:0]             rd_addr_1,
    output logic [8:0]             rd_addr_2,
    output logic [8:0]             rd_addr_3,
    input  logic [KEY_W+VAL_W:0]   rd_data_1,
    input  logic [KEY_W+VAL_W:0]   rd_data_2,
    input  logic [KEY_W+VAL_W:0]   rd_data_3,
    output logic                   lookup_done,
    output logic                   lookup_hit,
    output logic [VAL_W-1:0]       hit_value,
    output logic [1:0]             hit_table,
    output logic [8:0]             hit_addr,
    output logic                   proto_err,
    output logic                   key_overrun
);

    localparam int ENT_W = KEY_W + VAL_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_B0, S_WAIT_B1, S_CMP} state_t;

    state_t             state_q, state_d;
    logic [KEY_W-1:0]   key_q, key_d, key_cmp_q, key_cmp_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [8:0]         iss1_q, iss1_d, iss2_q, iss2_d, iss3_q, iss3_d;
    logic               fnd_q, fnd_d;
    logic [1:0]         fnd_tbl_q, fnd_tbl_d;
    logic [8:0]         fnd_addr_q, fnd_addr_d;
    logic [VAL_W-1:0]   fnd_val_q, fnd_val_d;
    logic               done_q, done_d, hit_q, hit_d;
    logic [VAL_W-1:0]   val_q, val_d;
    logic [1:0]         tbl_q, tbl_d;
    logic [8:0]         addr_q, addr_d;
    logic               perr_q, perr_d, ovr_q, ovr_d;

    logic               issue;
    logic [KEY_W-1:0]   cmp_key;
    logic               m1, m2, m3, b_hit;
    logic [1:0]         b_tbl;
    logic [8:0]         b_addr;
    logic [VAL_W-1:0]   b_val;

    function automatic logic ent_hit(input logic [ENT_W-1:0] e,
                                     input logic [KEY_W-1:0] k);
        return e[ENT_W-1] && (e[ENT_W-2:VAL_W] == k);
    endfunction

    assign key_ready = (state_q == S_IDLE) || (state_q == S_CMP);

    // Table priority within one beat, against whichever key owns the data.
    always_comb begin
        cmp_key = (state_q == S_CMP) ? key_cmp_q : key_q;
        m1      = ent_hit(rd_data_1, cmp_key);
        m2      = ent_hit(rd_data_2, cmp_key);
        m3      = ent_hit(rd_data_3, cmp_key);
        b_hit   = m1 | m2 | m3;
        b_tbl   = 2'd0;
        b_addr  = '0;
        b_val   = '0;
        if (m1) begin
            b_tbl  = 2'd1;
            b_addr = iss1_q;
            b_val  = rd_data_1[VAL_W-1:0];
        end else if (m2) begin
            b_tbl  = 2'd2;
            b_addr = iss2_q;
            b_val  = rd_data_2[VAL_W-1:0];
        end else if (m3) begin
            b_tbl  = 2'd3;
            b_addr = iss3_q;
            b_val  = rd_data_3[VAL_W-1:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        key_cmp_d  = key_cmp_q;
        tmo_d      = tmo_q;
        iss1_d     = iss1_q;
        iss2_d     = iss2_q;
        iss3_d     = iss3_q;
        fnd_d      = fnd_q;
        fnd_tbl_d  = fnd_tbl_q;
        fnd_addr_d = fnd_addr_q;
        fnd_val_d  = fnd_val_q;
        done_d     = 1'b0;
        hit_d      = hit_q;
        val_d      = val_q;
        tbl_d      = tbl_q;
        addr_d     = addr_q;
        perr_d     = 1'b0;
        ovr_d      = key_valid & ~key_ready;
        issue      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                perr_d = hash_value_valid;
                if (key_valid) begin
                    key_d   = key;
                    state_d = S_WAIT_B0;
                end
            end
            S_WAIT_B0: begin
                if (hash_value_valid) begin
                    if (!hash_1[8]) begin
                        issue   = 1'b1;
                        state_d = S_WAIT_B1;
                    end else begin
                        perr_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_WAIT_B1: begin
                if (!fnd_q && b_hit) begin
                    fnd_d      = 1'b1;
                    fnd_tbl_d  = b_tbl;
                    fnd_addr_d = b_addr;
                    fnd_val_d  = b_val;
                end
                if (hash_value_valid && hash_1[8]) begin
                    issue     = 1'b1;
                    key_cmp_d = key_q;
                    state_d   = S_CMP;
                end else begin
                    perr_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_CMP: begin
                done_d = 1'b1;
                perr_d = hash_value_valid;
                if (fnd_q) begin
                    hit_d  = 1'b1;
                    tbl_d  = fnd_tbl_q;
                    addr_d = fnd_addr_q;
                    val_d  = fnd_val_q;
                end else begin
                    hit_d  = b_hit;
                    tbl_d  = b_tbl;
                    addr_d = b_addr;
                    val_d  = b_val;
                end
                if (key_valid) begin
                    key_d   = key;
                    state_d = S_WAIT_B0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // A fresh key starts a clean lookup.
        if (key_valid && key_ready) begin
            tmo_d      = '0;
            fnd_d      = 1'b0;
            fnd_tbl_d  = 2'd0;
            fnd_addr_d = '0;
            fnd_val_d  = '0;
        end
        if (issue) begin
            iss1_d = hash_1;
            iss2_d = hash_2;
            iss3_d = hash_3;
        end
    end

    assign rd_en_1   = issue;
    assign rd_en_2   = issue;
    assign rd_en_3   = issue;
    assign rd_addr_1 = issue ? hash_1 : 9'd0;
    assign rd_addr_2 = issue ? hash_2 : 9'd0;
    assign rd_addr_3 = issue ? hash_3 : 9'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            key_q      <= '0;
            key_cmp_q  <= '0;
            tmo_q      <= '0;
            iss1_q     <= '0;
            iss2_q     <= '0;
            iss3_q     <= '0;
            fnd_q      <= 1'b0;
            fnd_tbl_q  <= 2'd0;
            fnd_addr_q <= '0;
            fnd_val_q  <= '0;
            done_q     <= 1'b0;
            hit_q      <= 1'b0;
            val_q      <= '0;
            tbl_q      <= 2'd0;
            addr_q     <= '0;
            perr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            key_cmp_q  <= key_cmp_d;
            tmo_q      <= tmo_d;
            iss1_q     <= iss1_d;
            iss2_q     <= iss2_d;
            iss3_q     <= iss3_d;
            fnd_q      <= fnd_d;
            fnd_tbl_q  <= fnd_tbl_d;
            fnd_addr_q <= fnd_addr_d;
            fnd_val_q  <= fnd_val_d;
            done_q     <= done_d;
            hit_q      <= hit_d;
            val_q      <= val_d;
            tbl_q      <= tbl_d;
            addr_q     <= addr_d;
            perr_q     <= perr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign lookup_done = done_q;
    assign lookup_hit  = hit_q;
    assign hit_value   = val_q;
    assign hit_table   = tbl_q;
    assign hit_addr    = addr_q;
    assign proto_err   = perr_q;
    assign key_overrun = ovr_q;

endmodule

// File: tb/tb_hash_probe.sv
// tb_hash_probe: directed scenarios for hash_probe against
// a registered three-table RAM model.
module tb_hash_probe;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          key_valid = 1'b0;
    logic [39:0]   key = '0;
    logic          key_ready;
    logic          hash_value_valid = 1'b0;
    logic [8:0]    hash_1 = '0, hash_2 = '0, hash_3 = '0;
    logic          rd_en_1, rd_en_2, rd_en_3;
    logic [8:0]    rd_addr_1, rd_addr_2, rd_addr_3;
    logic [56:0]   rd_data_1 = '0, rd_data_2 = '0, rd_data_3 = '0;
    logic          lookup_done, lookup_hit;
    logic [15:0]   hit_value;
    logic [1:0]    hit_table;
    logic [8:0]    hit_addr;
    logic          proto_err, key_overrun;

    logic [56:0]   t1 [512];
    logic [56:0]   t2 [512];
    logic [56:0]   t3 [512];

    int total = 0;
    int bad = 0;

    localparam logic [39:0] K1 = 40'hA5_0000_0003;
    localparam logic [39:0] K2 = 40'h12_3456_789A;
    localparam logic [39:0] K3 = 40'h00_0000_0001;
    localparam logic [39:0] K4 = 40'hC0_FFEE_0004;
    localparam logic [39:0] K5 = 40'h5A_5A5A_0005;

    hash_probe dut (
        .clk              (clk),
        .reset            (reset),
        .key_valid        (key_valid),
        .key              (key),
        .key_ready        (key_ready),
        .hash_value_valid (hash_value_valid),
        .hash_1           (hash_1),
        .hash_2           (hash_2),
        .hash_3           (hash_3),
        .rd_en_1          (rd_en_1),
        .rd_en_2          (rd_en_2),
        .rd_en_3          (rd_en_3),
        .rd_addr_1        (rd_addr_1),
        .rd_addr_2        (rd_addr_2),
        .rd_addr_3        (rd_addr_3),
        .rd_data_1        (rd_data_1),
        .rd_data_2        (rd_data_2),
        .rd_data_3        (rd_data_3),
        .lookup_done      (lookup_done),
        .lookup_hit       (lookup_hit),
        .hit_value        (hit_value),
        .hit_table        (hit_table),
        .hit_addr         (hit_addr),
        .proto_err        (proto_err),
        .key_overrun      (key_overrun)
    );

    always #5 clk = ~clk;

    // Bucket RAMs: data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en_1) rd_data_1 <= t1[rd_addr_1];
        if (rd_en_2) rd_data_2 <= t2[rd_addr_2];
        if (rd_en_3) rd_data_3 <= t3[rd_addr_3];
    end

    function automatic logic [56:0] ent(input logic v, input logic [39:0] k,
                                        input logic [15:0] val);
        return {v, k, val};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        key_valid = 1'b0;
        hash_value_valid = 1'b0;
        hash_1 = '0;
        hash_2 = '0;
        hash_3 = '0;
    endtask

    task automatic beat(input logic [8:0] a);
        hash_value_valid = 1'b1;
        hash_1 = a;
        hash_2 = a;
        hash_3 = a;
    endtask

    // Key, beat 0, beat 1; returns one cycle into CMP with inputs idle.
    task automatic lookup(input logic [39:0] k, input logic [8:0] a0,
                          input logic [8:0] a1);
        key_valid = 1'b1;
        key = k;
        tick();
        key_valid = 1'b0;
        beat(a0);
        tick();
        beat(a1);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_value, hit_table, hit_addr,
             proto_err, key_overrun, rd_en_1, rd_en_2, rd_en_3} !== 33'd0) begin
            bad++;
            $display("FAIL reset_outs: got lookup_done=%b hit=%b val=%h tbl=%0d addr=%h perr=%b ovr=%b, want all 0",
                     lookup_done, lookup_hit, hit_value, hit_table, hit_addr, proto_err, key_overrun);
        end
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b want 1", key_ready);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_hit();
        t2[9'h0A3] = ent(1'b1, K1, 16'h1234);
        key_valid = 1'b1;
        key = K1;
        tick();
        key_valid = 1'b0;
        beat(9'h0A3);
        #1;
        total++;
        if ({rd_en_1, rd_en_2, rd_en_3, rd_addr_2} !== {3'b111, 9'h0A3}) begin
            bad++;
            $display("FAIL basic_issue: got en=%b%b%b addr2=%h want 111 0a3",
                     rd_en_1, rd_en_2, rd_en_3, rd_addr_2);
        end
        total++;
        if (key_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_ready_b0: got %b want 0", key_ready);
        end
        tick();
        beat(9'h1A3);
        tick();
        idle();
        total++;
        if (lookup_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_early_done: got %b want 0", lookup_done);
        end
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b1, 2'd2, 9'h0A3, 16'h1234}) begin
            bad++;
            $display("FAIL basic_result: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 1 2 0a3 1234",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        tick();
        total++;
        if (lookup_done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_pulse: got %b want 0", lookup_done);
        end
    endtask

    task automatic test_beat_priority();
        t1[9'h155] = ent(1'b1, K2, 16'h1111);
        t2[9'h155] = ent(1'b1, K2, 16'h2222);
        t3[9'h055] = ent(1'b1, K2, 16'h3333);
        lookup(K2, 9'h055, 9'h155);
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b1, 2'd3, 9'h055, 16'h3333}) begin
            bad++;
            $display("FAIL beat0_wins: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 1 3 055 3333",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        tick();
    endtask

    task automatic test_invalid_entry();
        t1[9'h010] = ent(1'b0, K3, 16'hBEEF);
        t2[9'h010] = ent(1'b0, K3, 16'hBEEF);
        t3[9'h010] = ent(1'b0, K3, 16'hBEEF);
        t1[9'h110] = ent(1'b0, K3, 16'hBEEF);
        t2[9'h110] = ent(1'b0, K3, 16'hBEEF);
        t3[9'h110] = ent(1'b0, K3, 16'hBEEF);
        lookup(K3, 9'h010, 9'h110);
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b0, 2'd0, 9'h000, 16'h0000}) begin
            bad++;
            $display("FAIL invalid_miss: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 0 0 000 0000",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        t1[9'h020] = ent(1'b1, K4, 16'hAAAA);
        t2[9'h020] = ent(1'b1, K4, 16'hBBBB);
        t2[9'h130] = ent(1'b1, K5, 16'h5555);
        key_valid = 1'b1;
        key = K4;
        tick();
        key = K5;
        beat(9'h020);
        tick();
        total++;
        if (key_overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_pulse: got %b want 1", key_overrun);
        end
        key_valid = 1'b0;
        beat(9'h120);
        tick();
        total++;
        if ({key_overrun, key_ready} !== 2'b01) begin
            bad++;
            $display("FAIL cmp_ready: got ovr=%b ready=%b want 0 1", key_overrun, key_ready);
        end
        hash_value_valid = 1'b0;
        key_valid = 1'b1;
        key = K5;
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b1, 2'd1, 9'h020, 16'hAAAA}) begin
            bad++;
            $display("FAIL b2b_first: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 1 1 020 aaaa",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        key_valid = 1'b0;
        beat(9'h030);
        tick();
        total++;
        if (lookup_done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got %b want 0", lookup_done);
        end
        beat(9'h130);
        tick();
        idle();
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b1, 2'd2, 9'h130, 16'h5555}) begin
            bad++;
            $display("FAIL b2b_second: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 1 2 130 5555",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        tick();
    endtask

    task automatic test_proto_err();
        // Beat 1 withheld.
        key_valid = 1'b1;
        key = K1;
        tick();
        key_valid = 1'b0;
        beat(9'h0A3);
        tick();
        idle();
        tick();
        total++;
        if ({proto_err, key_ready, lookup_done} !== 3'b110) begin
            bad++;
            $display("FAIL no_beat1: got perr=%b ready=%b done=%b want 1 1 0",
                     proto_err, key_ready, lookup_done);
        end
        tick();
        total++;
        if ({proto_err, lookup_done} !== 2'b00) begin
            bad++;
            $display("FAIL no_beat1_after: got perr=%b done=%b want 0 0", proto_err, lookup_done);
        end
        // Beat with MSB=1 while waiting for beat 0.
        key_valid = 1'b1;
        key = K1;
        tick();
        key_valid = 1'b0;
        beat(9'h1A3);
        tick();
        idle();
        total++;
        if ({proto_err, key_ready, lookup_done} !== 3'b110) begin
            bad++;
            $display("FAIL wrong_beat: got perr=%b ready=%b done=%b want 1 1 0",
                     proto_err, key_ready, lookup_done);
        end
        tick();
        // Hash beat while idle.
        beat(9'h0A3);
        tick();
        idle();
        total++;
        if ({proto_err, key_ready} !== 2'b11) begin
            bad++;
            $display("FAIL idle_beat: got perr=%b ready=%b want 1 1", proto_err, key_ready);
        end
        tick();
        // No beat at all: abort after 8 waiting cycles.
        key_valid = 1'b1;
        key = K1;
        tick();
        key_valid = 1'b0;
        repeat (7) tick();
        total++;
        if ({proto_err, key_ready} !== 2'b00) begin
            bad++;
            $display("FAIL timeout_early: got perr=%b ready=%b want 0 0", proto_err, key_ready);
        end
        tick();
        total++;
        if ({proto_err, key_ready, lookup_done} !== 3'b110) begin
            bad++;
            $display("FAIL timeout: got perr=%b ready=%b done=%b want 1 1 0",
                     proto_err, key_ready, lookup_done);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        key_valid = 1'b1;
        key = K1;
        tick();
        key_valid = 1'b0;
        beat(9'h0A3);
        tick();
        idle();
        reset = 1'b0;
        #1;
        total++;
        if ({lookup_done, lookup_hit, hit_value, hit_table, hit_addr,
             proto_err, key_overrun} !== 30'd0) begin
            bad++;
            $display("FAIL midreset_outs: got done=%b hit=%b val=%h tbl=%0d addr=%h perr=%b ovr=%b want all 0",
                     lookup_done, lookup_hit, hit_value, hit_table, hit_addr, proto_err, key_overrun);
        end
        total++;
        if (key_ready !== 1'b1) begin
            bad++;
            $display("FAIL midreset_ready: got %b want 1", key_ready);
        end
        tick();
        tick();
        reset = 1'b1;
        total++;
        if (lookup_done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_nodone: got %b want 0", lookup_done);
        end
        lookup(K1, 9'h0A3, 9'h1A3);
        tick();
        total++;
        if ({lookup_done, lookup_hit, hit_table, hit_addr, hit_value} !==
            {1'b1, 1'b1, 2'd2, 9'h0A3, 16'h1234}) begin
            bad++;
            $display("FAIL post_reset: got done=%b hit=%b tbl=%0d addr=%h val=%h want 1 1 2 0a3 1234",
                     lookup_done, lookup_hit, hit_table, hit_addr, hit_value);
        end
        tick();
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            t1[i] = '0;
            t2[i] = '0;
            t3[i] = '0;
        end
        test_reset();
        test_basic_hit();
        test_beat_priority();
        test_invalid_entry();
        test_back_to_back();
        test_proto_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hash_probe.md
Name: hash_probe

Overview:
- Consumer at the far end of the hash-value interface.
- Latches a 40-bit lookup key and collects the two hash beats the hash generator emits for it: beat 0 with address MSB=0, then beat 1 with MSB=1.
- Issues reads to three 512-entry bucket tables and compares the stored keys against the lookup key.
- Reports one registered result per lookup: hit/miss, value, table, address; or a protocol error.

Parameters:
- KEY_W, 40, lookup key width.
- VAL_W, 16, stored value width; table entry = {valid, key[KEY_W-1:0], value[VAL_W-1:0]} = 57 bits.
- TIMEOUT, 8, max cycles waited in WAIT_B0 for beat 0 before aborting.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- key_valid  in  1  key presented this cycle; accepted only when key_ready=1.
- key  in  KEY_W  lookup key.
- key_ready  out  1  block can accept a key this cycle.
- hash_value_valid  in  1  hash beat valid.
- hash_1, hash_2, hash_3  in  9 each  bucket addresses for tables 1..3; bit 8 = beat index.
- rd_en_1, rd_en_2, rd_en_3  out  1 each  table read strobes.
- rd_addr_1, rd_addr_2, rd_addr_3  out  9 each  table read addresses.
- rd_data_1, rd_data_2, rd_data_3  in  57 each  read data, valid the cycle after rd_en.
- lookup_done  out  1  one-cycle pulse: result valid.
- lookup_hit  out  1  hit flag, qualified by lookup_done.
- hit_value  out  VAL_W  value of the winning entry; 0 on miss.
- hit_table  out  2  1..3 = winning table; 0 on miss.
- hit_addr  out  9  address of the winning entry; 0 on miss.
- proto_err  out  1  one-cycle pulse on protocol violation.
- key_overrun  out  1  one-cycle pulse: key_valid while key_ready=0; that key is ignored.

Behaviour:
- Reset (async, reset=0): every output 0 except key_ready=1. State=IDLE, internal key/hit registers cleared.
- Reset mid-lookup aborts it; no lookup_done is produced.
- key_ready is combinational: 1 in IDLE and CMP, else 0. Upstream gates the hash generator's key_valid with key_ready.
- All other outputs are registered.
- rd_en/rd_addr are combinational from hash inputs in the issuing state: rd_en_x=1, rd_addr_x=hash_x.
- Entry hit for table x: rd_data_x[56]=1 and rd_data_x[55:16]==key. Priority: beat 0 over beat 1, then table 1 > 2 > 3. The first hit is sticky.
- States:
  - IDLE: key_valid → key_q<=key, clear hit regs, →WAIT_B0. hash_value_valid here → proto_err, stay.
  - WAIT_B0: timeout counter runs.
    - hash_value_valid with hash_1[8]=0 → issue reads, →WAIT_B1.
    - hash_value_valid with hash_1[8]=1 → proto_err, →IDLE, no lookup_done.
    - Counter reaches TIMEOUT with no beat → proto_err, →IDLE.
  - WAIT_B1: compare beat-0 rd_data against key_q and record any hit.
    - Requires hash_value_valid with hash_1[8]=1 this cycle → issue reads, key_cmp<=key_q, →CMP.
    - Otherwise → proto_err, →IDLE, beat-0 result discarded.
  - CMP: compare beat-1 rd_data against key_cmp. Register final result; lookup_done=1 next cycle.
    - key_valid here → key_q<=key, →WAIT_B0.
    - Otherwise →IDLE.
    - hash_value_valid here → proto_err.
- Latency: key at T, beat 0 at T+1, beat 1 at T+2, CMP at T+3, lookup_done at T+4. Throughput: one key per 3 cycles.
- hash_2/hash_3 bit 8 is not checked; only hash_1[8] identifies the beat.
- Result outputs hold their values until the next lookup_done. lookup_done, proto_err and key_overrun are single-cycle pulses.

Test Plan:
- Key 0xA5_0000_0003 at T; beat 0 addresses 0x0A3; table 2 at 0x0A3 holds {1, same key, 0x1234} → lookup_done at T+4, hit=1, hit_table=2, hit_addr=0x0A3, hit_value=0x1234.
- Same key present in table 1 at beat-1 address 0x1A3 and in table 3 at beat-0 address 0x0A3 → hit_table=3, hit_addr=0x0A3 (beat 0 wins).
- Key matches but valid bit=0 in every probed entry → lookup_hit=0, hit_table=0, hit_value=0.
- Back-to-back keys K1 at T, K2 at T+3 (CMP) → K2 accepted. Two lookup_done pulses at T+4 and T+7 with independent results. key_valid at T+1 → key_overrun pulse, key ignored.
- Beat 1 withheld after beat 0 → proto_err next cycle, no lookup_done, key_ready=1. Beat with MSB=1 in WAIT_B0 → proto_err. No beat for 8 cycles → proto_err.
- Assert reset in WAIT_B1 → outputs 0 immediately, key_ready=1. Lookup after release completes normally.
